// File: rtl/ravenoc_pkg.sv
// Shared RaveNoC types: flit type encoding carried in the top bits of every flit,
// and the output-port arbiter state.
package ravenoc_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic is_head(input flit_type_t t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/rr_prio_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
// The request vector is doubled so the wrap-around becomes a plain priority scan.
module rr_prio_picker #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_grant
);

  always_comb begin
    logic [2*N-1:0] masked;
    masked    = {req, req};
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    // lower copy only keeps positions at or above ptr; the upper copy covers the wrap
    for (int j = 0; j < N; j++) begin
      if (j < int'(ptr)) masked[j] = 1'b0;
    end
    for (int j = 0; j < 2 * N; j++) begin
      if (masked[j] && !any_grant) begin
        any_grant    = 1'b1;
        idx          = IDX_W'(j % N);
        grant[j % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// Wormhole output-port arbiter and flit mux: round-robin on head flits, grant held
// until the tail is accepted, plus a stall watchdog and a sticky protocol-error flag.
module noc_out_port_arbiter
  import ravenoc_pkg::*;
#(
  parameter int N_INPUTS       = 5,
  parameter int FLIT_WIDTH     = 34,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            in_valid,
  input  logic [N_INPUTS*FLIT_WIDTH-1:0] in_data,
  output logic [N_INPUTS-1:0]            in_ready,
  output logic                           out_valid,
  output logic [FLIT_WIDTH-1:0]          out_data,
  input  logic                           out_ready,
  output logic                           lock_o,
  output logic [IDX_W-1:0]               owner_o,
  output logic                           err_proto_o,
  output logic                           timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t          state, state_next;
  logic [IDX_W-1:0]    ptr, ptr_next;
  logic [IDX_W-1:0]    owner, owner_next;
  logic [CNT_W-1:0]    wd_cnt, wd_cnt_next;
  logic                err_proto, err_next;
  logic                timeout, timeout_next;

  flit_type_t          in_type [N_INPUTS];
  logic [N_INPUTS-1:0] head_req, bad_idle, pick_onehot;
  logic [IDX_W-1:0]    pick_idx, grant_idx;
  logic                pick_any, transfer;
  flit_type_t          grant_type;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (int'(i) == N_INPUTS - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      in_type[i]  = flit_type_t'(in_data[i*FLIT_WIDTH + FLIT_WIDTH - 1 -: FLIT_TYPE_W]);
      head_req[i] = in_valid[i] && is_head(in_type[i]);
      bad_idle[i] = in_valid[i] && !is_head(in_type[i]);
    end
  end

  rr_prio_picker #(
    .N     (N_INPUTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req       (head_req),
    .ptr       (ptr),
    .grant     (pick_onehot),
    .idx       (pick_idx),
    .any_grant (pick_any)
  );

  // The mux path is purely combinational so a flit can leave in the cycle it arrives.
  always_comb begin
    grant_idx  = (state == LOCKED) ? owner : pick_idx;
    out_valid  = !rst && ((state == LOCKED) ? in_valid[owner] : pick_any);
    out_data   = in_data[int'(grant_idx)*FLIT_WIDTH +: FLIT_WIDTH];
    grant_type = in_type[grant_idx];
    transfer   = out_valid && out_ready;
    in_ready   = '0;
    if (transfer) begin
      in_ready = (state == LOCKED) ? (N_INPUTS'(1) << owner) : pick_onehot;
    end
  end

  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    owner_next   = owner;
    wd_cnt_next  = wd_cnt;
    err_next     = err_proto;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (|bad_idle) err_next = 1'b1;
        if (transfer) begin
          owner_next = grant_idx;
          if (grant_type == HEAD) begin
            state_next  = LOCKED;
            wd_cnt_next = '0;
          end else begin
            ptr_next = wrap_inc(grant_idx);
          end
        end
      end
      LOCKED: begin
        if (out_valid && is_head(grant_type)) err_next = 1'b1;
        if (transfer) begin
          wd_cnt_next = '0;
          if (grant_type == TAIL) begin
            state_next = IDLE;
            ptr_next   = wrap_inc(owner);
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          // a stalled packet is abandoned, not repaired; upstream owns the cleanup
          if (wd_cnt == CNT_LAST) begin
            state_next   = IDLE;
            ptr_next     = wrap_inc(owner);
            wd_cnt_next  = '0;
            timeout_next = 1'b1;
          end else begin
            wd_cnt_next = wd_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      wd_cnt    <= '0;
      err_proto <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      owner     <= owner_next;
      wd_cnt    <= wd_cnt_next;
      err_proto <= err_next;
      timeout   <= timeout_next;
    end
  end

  assign lock_o      = (state == LOCKED);
  assign owner_o     = owner;
  assign err_proto_o = err_proto;
  assign timeout_o   = timeout;

endmodule
